// File: rtl/bitgen_layered.sv
// Two-stage layered pixel colour generator: fixed-priority foreground layers over a background,
// with colour-key transparency and per-layer frame blink. Optional invert port under BITGEN_INVERT_EN.
module bitgen_layered #(
    parameter int unsigned         COLOR_W      = 24,
    parameter int unsigned         LAYERS       = 2,
    parameter logic [COLOR_W-1:0]  TRANSPARENT  = '0,
    parameter int unsigned         BLINK_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        vga_blank_n,
    input  logic                        frame_start,
    input  logic [LAYERS-1:0]           pixel_en,
    input  logic [LAYERS*COLOR_W-1:0]   fg_pixel,
    input  logic [COLOR_W-1:0]          bg_pixel,
    input  logic [LAYERS-1:0]           blink_en,
`ifdef BITGEN_INVERT_EN
    input  logic                        invert,
`endif
    output logic [COLOR_W-1:0]          rgb,
    output logic                        blank_n_out
);

    localparam int unsigned CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned FG_W     = LAYERS * COLOR_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic                   r_blank_n;
    logic [LAYERS-1:0]      r_pixel_en;
    logic [FG_W-1:0]        r_fg;
    logic [COLOR_W-1:0]     r_bg;
    logic [LAYERS-1:0]      r_blink_en;
    logic                   r_invert;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic                   r_blink_phase;

    logic [LAYERS-1:0]      w_vis;
    logic [COLOR_W-1:0]     w_sel;
    logic                   w_found;
    logic                   w_invert;
    logic [COLOR_W-1:0]     w_rgb_nxt;

`ifdef BITGEN_INVERT_EN
    assign w_invert = invert;
`else
    assign w_invert = 1'b0;
`endif

    // Stage 1: register all pixel inputs unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blank_n  <= 1'b0;
            r_pixel_en <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_blink_en <= '0;
            r_invert   <= 1'b0;
        end else begin
            r_blank_n  <= vga_blank_n;
            r_pixel_en <= pixel_en;
            r_fg       <= fg_pixel;
            r_bg       <= bg_pixel;
            r_blink_en <= blink_en;
            r_invert   <= w_invert;
        end
    end

    // Blink timebase, advanced only by frame_start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_frame_cnt == CNT_LAST) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_vis = '0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            w_vis[i] = r_pixel_en[i]
                     && (r_fg[i*COLOR_W +: COLOR_W] != TRANSPARENT)
                     && !(r_blink_en[i] && r_blink_phase);
        end
    end

    // Lowest-index visible layer wins; background when none is visible
    always_comb begin
        w_sel   = r_bg;
        w_found = 1'b0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            if (!w_found && w_vis[i]) begin
                w_sel   = r_fg[i*COLOR_W +: COLOR_W];
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_rgb_nxt = '0;
        if (r_blank_n) begin
            w_rgb_nxt = r_invert ? ~w_sel : w_sel;
        end
    end

    // Stage 2: registered colour and aligned blank
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb         <= '0;
            blank_n_out <= 1'b0;
        end else begin
            rgb         <= w_rgb_nxt;
            blank_n_out <= r_blank_n;
        end
    end

endmodule

// File: tb/tb_bitgen_layered.sv
// Self-checking bench for bitgen_layered: directed scenarios plus randomized streaming against
// a behavioural model (pulse count -> blink phase, first-visible-layer select, 2-cycle delay).
module tb_bitgen_layered;

    localparam int unsigned CW = 24;
    localparam int unsigned NL = 2;
    localparam int unsigned BF = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              vga_blank_n;
    logic              frame_start;
    logic [NL-1:0]     pixel_en;
    logic [NL*CW-1:0]  fg_pixel;
    logic [CW-1:0]     bg_pixel;
    logic [NL-1:0]     blink_en;
    logic              invert;
    logic [CW-1:0]     rgb;
    logic              blank_n_out;

    int total = 0;
    int bad   = 0;

    // model state
    int            pulses = 0;
    logic [CW-1:0] pipe_rgb = '0, exp_rgb = '0;
    logic          pipe_bn = 1'b0, exp_bn = 1'b0;

    bitgen_layered #(.COLOR_W(CW), .LAYERS(NL), .TRANSPARENT(24'h000000), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .reset       (reset),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start),
        .pixel_en    (pixel_en),
        .fg_pixel    (fg_pixel),
        .bg_pixel    (bg_pixel),
        .blink_en    (blink_en),
`ifdef BITGEN_INVERT_EN
        .invert      (invert),
`endif
        .rgb         (rgb),
        .blank_n_out (blank_n_out)
    );

    always #5 clk = ~clk;

    // Expected pixel for the current inputs given the blink phase implied by the pulse count
    function automatic logic [CW:0] model_pixel(int npulses);
        logic [CW-1:0] c;
        logic [CW-1:0] f;
        bit            phase;
        bit            done;
        phase = ((npulses / BF) % 2) == 1;
        c     = bg_pixel;
        done  = 0;
        for (int i = 0; i < NL; i++) begin
            f = fg_pixel[i*CW +: CW];
            if (!done && pixel_en[i] && f != 24'h000000 && !(blink_en[i] && phase)) begin
                c    = f;
                done = 1;
            end
        end
`ifdef BITGEN_INVERT_EN
        if (invert) c = ~c;
`endif
        if (!vga_blank_n) return {1'b0, 24'h000000};
        return {1'b1, c};
    endfunction

    // Advance one clock, update the model, land 1 time unit after the edge
    task automatic tick();
        logic [CW:0] m;
        @(posedge clk);
        if (reset) begin
            pulses   = 0;
            exp_rgb  = '0;
            exp_bn   = 1'b0;
            pipe_rgb = '0;
            pipe_bn  = 1'b0;
        end else begin
            exp_rgb = pipe_rgb;
            exp_bn  = pipe_bn;
            if (frame_start) pulses++;
            m        = model_pixel(pulses);
            pipe_bn  = m[CW];
            pipe_rgb = m[CW-1:0];
        end
        #1;
    endtask

    task automatic set_px(input logic bn, input logic [NL-1:0] pe, input logic [CW-1:0] f0,
                          input logic [CW-1:0] f1, input logic [CW-1:0] bg, input logic [NL-1:0] be);
        vga_blank_n = bn;
        pixel_en    = pe;
        fg_pixel    = {f1, f0};
        bg_pixel    = bg;
        blink_en    = be;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; invert = 1'b0;
        set_px(1'b1, 2'b11, 24'h111111, 24'h222222, 24'h333333, 2'b00);
        repeat (3) tick();
        total++;
        if (rgb !== 24'h0 || blank_n_out !== 1'b0) begin
            bad++; $display("FAIL reset_state rgb=%h bn=%b want 000000/0", rgb, blank_n_out);
        end
        reset = 1'b0;
        set_px(1'b1, 2'b01, 24'hFF0000, 24'h0, 24'h0000FF, 2'b00);
        tick();
        total++;
        if (rgb !== 24'h0 || blank_n_out !== 1'b0) begin
            bad++; $display("FAIL latency_c1 rgb=%h bn=%b want 000000/0", rgb, blank_n_out);
        end
        tick();
        total++;
        if (rgb !== 24'hFF0000 || blank_n_out !== 1'b1) begin
            bad++; $display("FAIL latency_c2 rgb=%h bn=%b want ff0000/1", rgb, blank_n_out);
        end
    endtask

    task automatic test_priority();
        set_px(1'b1, 2'b11, 24'h00FF00, 24'hFFFFFF, 24'h0000FF, 2'b00);
        repeat (2) tick();
        total++;
        if (rgb !== 24'h00FF00) begin
            bad++; $display("FAIL priority rgb=%h want 00ff00", rgb);
        end
        set_px(1'b1, 2'b11, 24'h000000, 24'hFFFFFF, 24'h0000FF, 2'b00);
        repeat (2) tick();
        total++;
        if (rgb !== 24'hFFFFFF) begin
            bad++; $display("FAIL transparent rgb=%h want ffffff", rgb);
        end
        set_px(1'b1, 2'b00, 24'h00FF00, 24'hFFFFFF, 24'h0000FF, 2'b00);
        repeat (2) tick();
        total++;
        if (rgb !== 24'h0000FF) begin
            bad++; $display("FAIL background rgb=%h want 0000ff", rgb);
        end
    endtask

    task automatic test_blanking();
        set_px(1'b0, 2'b11, 24'h00FF00, 24'hFFFFFF, 24'h0000FF, 2'b00);
        tick();
        total++;
        if (rgb !== 24'h0000FF || blank_n_out !== 1'b1) begin
            bad++; $display("FAIL blank_c1 rgb=%h bn=%b want 0000ff/1", rgb, blank_n_out);
        end
        tick();
        total++;
        if (rgb !== 24'h0 || blank_n_out !== 1'b0) begin
            bad++; $display("FAIL blank_c2 rgb=%h bn=%b want 000000/0", rgb, blank_n_out);
        end
    endtask

    task automatic test_blink();
        logic [CW-1:0] want;
        set_px(1'b1, 2'b01, 24'h123456, 24'h0, 24'hABCDEF, 2'b01);
        repeat (2) tick();
        total++;
        if (rgb !== 24'h123456) begin
            bad++; $display("FAIL blink_p0 rgb=%h want 123456", rgb);
        end
        for (int p = 1; p <= 6; p++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            repeat (1 + p % 3) tick();
            want = (p >= 3 && p < 6) ? 24'hABCDEF : 24'h123456;
            total++;
            if (rgb !== want) begin
                bad++; $display("FAIL blink_pulse%0d rgb=%h want %h", p, rgb, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 3; p++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        end
        set_px(1'b1, 2'b01, 24'h123456, 24'h0, 24'hABCDEF, 2'b01);
        repeat (2) tick();
        total++;
        if (rgb !== 24'hABCDEF) begin
            bad++; $display("FAIL premid_phase rgb=%h want abcdef", rgb);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (rgb !== 24'h0 || blank_n_out !== 1'b0) begin
            bad++; $display("FAIL mid_reset_c0 rgb=%h bn=%b want 000000/0", rgb, blank_n_out);
        end
        tick();
        total++;
        if (rgb !== 24'h0 || blank_n_out !== 1'b0) begin
            bad++; $display("FAIL mid_reset_c1 rgb=%h bn=%b want 000000/0", rgb, blank_n_out);
        end
        tick();
        total++;
        if (rgb !== 24'h123456 || blank_n_out !== 1'b1) begin
            bad++; $display("FAIL mid_reset_resume rgb=%h bn=%b want 123456/1", rgb, blank_n_out);
        end
        for (int p = 1; p <= 3; p++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0; repeat (2) tick();
            total++;
            if (rgb !== ((p == 3) ? 24'hABCDEF : 24'h123456)) begin
                bad++; $display("FAIL mid_reset_cnt%0d rgb=%h", p, rgb);
            end
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] f0, f1;
        for (int n = 0; n < 400; n++) begin
            f0 = ($urandom_range(0, 3) == 0) ? 24'h0 : CW'($urandom);
            f1 = ($urandom_range(0, 3) == 0) ? 24'h0 : CW'($urandom);
            set_px(($urandom_range(0, 9) != 0), NL'($urandom), f0, f1, CW'($urandom), NL'($urandom));
            frame_start = ($urandom_range(0, 5) == 0);
`ifdef BITGEN_INVERT_EN
            invert = ($urandom_range(0, 3) == 0);
`endif
            reset = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if (rgb !== exp_rgb || blank_n_out !== exp_bn) begin
                bad++; $display("FAIL random_%0d rgb=%h bn=%b want %h/%b", n, rgb, blank_n_out, exp_rgb, exp_bn);
            end
        end
        reset = 1'b0; frame_start = 1'b0; invert = 1'b0;
    endtask

`ifdef BITGEN_INVERT_EN
    task automatic test_invert();
        reset = 1'b1; tick(); reset = 1'b0;
        invert = 1'b1;
        set_px(1'b1, 2'b01, 24'h0F0F0F, 24'h0, 24'h0000FF, 2'b00);
        repeat (2) tick();
        total++;
        if (rgb !== 24'hF0F0F0) begin
            bad++; $display("FAIL invert rgb=%h want f0f0f0", rgb);
        end
        vga_blank_n = 1'b0;
        repeat (2) tick();
        total++;
        if (rgb !== 24'h0 || blank_n_out !== 1'b0) begin
            bad++; $display("FAIL invert_blank rgb=%h bn=%b want 000000/0", rgb, blank_n_out);
        end
        invert = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_blanking();
        test_blink();
        test_reset_mid();
`ifdef BITGEN_INVERT_EN
        test_invert();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
